// File: rtl/asyn_rd_ctrl.sv
// Read-side controller for an asynchronous FIFO: synchronizes the comparator
// empty flag, paces RAM fetches and buffers words in a 2-entry output FIFO.
module asyn_rd_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  rst,
    input  logic                  asyn_empty,
    output logic [ADDR_WIDTH-1:0] r_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  r_empty
);

    localparam int unsigned HOLD_W = 2;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } buf_state_e;

    logic                  sync1_q, sync2_q, r_empty_q;
    logic [HOLD_W-1:0]     holdoff_q, holdoff_d;
    logic [ADDR_WIDTH-1:0] bin_q, bin_d;
    logic [ADDR_WIDTH-1:0] gray_q, gray_d;
    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  pop_c, fetch_c;

    assign pop_c   = dout_valid_q & dout_ready;
    // Hold-off keeps every fetch decision behind the latest r_ptr change.
    assign fetch_c = sync2_q & (holdoff_q == '0) & ((state_q != B2) | pop_c);

    always_comb begin
        holdoff_d    = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : holdoff_q;
        bin_d        = bin_q;
        state_d      = state_q;
        ent0_d       = ent0_q;
        ent1_d       = ent1_q;

        if (fetch_c) begin
            holdoff_d = HOLD_W'(2);
            bin_d     = bin_q + ADDR_WIDTH'(1);
        end
        gray_d = (bin_d >> 1) ^ bin_d;

        // ent0 is the head; a new word always lands behind any survivor.
        case (state_q)
            B0: begin
                if (fetch_c) begin
                    ent0_d  = ram_rdata;
                    state_d = B1;
                end
            end
            B1: begin
                if (fetch_c && !pop_c) begin
                    ent1_d  = ram_rdata;
                    state_d = B2;
                end else if (fetch_c && pop_c) begin
                    ent0_d  = ram_rdata;
                end else if (pop_c) begin
                    state_d = B0;
                end
            end
            B2: begin
                if (pop_c) begin
                    ent0_d = ent1_q;
                    if (fetch_c) begin
                        ent1_d = ram_rdata;
                    end else begin
                        state_d = B1;
                    end
                end
            end
            default: state_d = B0;
        endcase

        dout_valid_d = (state_d != B0);
    end

    always_ff @(posedge r_clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            r_empty_q    <= 1'b1;
            holdoff_q    <= '0;
            bin_q        <= '0;
            gray_q       <= '0;
            state_q      <= B0;
            ent0_q       <= '0;
            ent1_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            sync1_q      <= asyn_empty;
            sync2_q      <= sync1_q;
            r_empty_q    <= ~sync1_q;
            holdoff_q    <= holdoff_d;
            bin_q        <= bin_d;
            gray_q       <= gray_d;
            state_q      <= state_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign r_ptr      = gray_q;
    assign r_addr     = bin_q;
    assign dout       = ent0_q;
    assign dout_valid = dout_valid_q;
    assign r_empty    = r_empty_q;

endmodule

// File: tb/tb_asyn_rd_ctrl.sv
// Directed bench for asyn_rd_ctrl: sync latency, fetch pacing, wrap,
// back-pressure, empty drop and mid-operation reset.
module tb_asyn_rd_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          r_clk = 1'b0;
    logic          rst;
    logic          asyn_empty;
    logic [AW-1:0] r_ptr, r_addr;
    logic [DW-1:0] ram_rdata, dout;
    logic          dout_valid, dout_ready, r_empty;

    logic [DW-1:0] mem [16];
    logic [AW-1:0] gray_tbl [16];

    int checks = 0;
    int errors = 0;

    asyn_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .r_clk      (r_clk),
        .rst        (rst),
        .asyn_empty (asyn_empty),
        .r_ptr      (r_ptr),
        .r_addr     (r_addr),
        .ram_rdata  (ram_rdata),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .r_empty    (r_empty)
    );

    always #5 r_clk = ~r_clk;

    assign ram_rdata = mem[r_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    initial begin
        gray_tbl = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                     4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'h3C ^ (i * 8'h11));

        rst = 1'b1; asyn_empty = 1'b0; dout_ready = 1'b1;
        step(2);
        chk("rst_r_empty", 32'(r_empty), 32'd1);
        chk("rst_valid",   32'(dout_valid), 32'd0);
        chk("rst_dout",    32'(dout), 32'd0);
        rst = 1'b0;

        // Empty FIFO: nothing may be fetched.
        step(10);
        chk("idle_r_empty", 32'(r_empty), 32'd1);
        chk("idle_valid",   32'(dout_valid), 32'd0);
        chk("idle_r_ptr",   32'(r_ptr), 32'd0);
        chk("idle_r_addr",  32'(r_addr), 32'd0);

        // Two-flop synchronizer latency, then first fetch.
        asyn_empty = 1'b1;
        step(1);
        chk("sync1_r_empty", 32'(r_empty), 32'd1);
        step(1);
        chk("sync2_r_empty", 32'(r_empty), 32'd0);
        chk("sync2_valid",   32'(dout_valid), 32'd0);
        step(1);
        chk("first_valid", 32'(dout_valid), 32'd1);
        chk("first_dout",  32'(dout), 32'(mem[0]));
        chk("first_addr",  32'(r_addr), 32'd1);
        chk("first_ptr",   32'(r_ptr), 32'(gray_tbl[1]));

        // Streaming at one word per three cycles through the pointer wrap.
        for (int i = 1; i <= 16; i++) begin
            step(1);
            chk("stream_gap1", 32'(dout_valid), 32'd0);
            step(1);
            chk("stream_gap2", 32'(dout_valid), 32'd0);
            step(1);
            chk("stream_valid", 32'(dout_valid), 32'd1);
            chk("stream_dout",  32'(dout), 32'(mem[i % 16]));
            chk("stream_addr",  32'(r_addr), 32'((i + 1) % 16));
            chk("stream_ptr",   32'(r_ptr), 32'(gray_tbl[(i + 1) % 16]));
        end

        // Empty asserted right after a fetch: no further fetch.
        asyn_empty = 1'b0;
        step(2);
        chk("drop_r_empty", 32'(r_empty), 32'd1);
        step(5);
        chk("drop_addr",  32'(r_addr), 32'd1);
        chk("drop_valid", 32'(dout_valid), 32'd0);

        // Back-pressure: exactly two fetches, then hold.
        dout_ready = 1'b0; asyn_empty = 1'b1;
        step(3);
        chk("bp_fetch1_dout", 32'(dout), 32'(mem[1]));
        chk("bp_fetch1_addr", 32'(r_addr), 32'd2);
        step(3);
        chk("bp_fetch2_addr", 32'(r_addr), 32'd3);
        step(6);
        chk("bp_hold_addr",  32'(r_addr), 32'd3);
        chk("bp_hold_dout",  32'(dout), 32'(mem[1]));
        chk("bp_hold_valid", 32'(dout_valid), 32'd1);

        // Release: pop and fetch together, order kept.
        dout_ready = 1'b1;
        step(1);
        chk("rel_dout0", 32'(dout), 32'(mem[2]));
        chk("rel_addr0", 32'(r_addr), 32'd4);
        step(1);
        chk("rel_dout1",  32'(dout), 32'(mem[3]));
        chk("rel_valid1", 32'(dout_valid), 32'd1);
        step(1);
        chk("rel_valid2", 32'(dout_valid), 32'd0);
        step(1);
        chk("rel_dout3",  32'(dout), 32'(mem[4]));
        chk("rel_addr3",  32'(r_addr), 32'd5);

        // Fill to two entries, then reset while hold-off is 1.
        dout_ready = 1'b0;
        step(3);
        chk("b2_addr", 32'(r_addr), 32'd6);
        chk("b2_dout", 32'(dout), 32'(mem[4]));
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_ptr",     32'(r_ptr), 32'd0);
        chk("mrst_addr",    32'(r_addr), 32'd0);
        chk("mrst_dout",    32'(dout), 32'd0);
        chk("mrst_valid",   32'(dout_valid), 32'd0);
        chk("mrst_r_empty", 32'(r_empty), 32'd1);
        step(2);
        chk("post_rst_valid", 32'(dout_valid), 32'd0);
        chk("post_rst_addr",  32'(r_addr), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
